// File: rtl/random_word_pool.sv
// random_word_pool: samples a free-running 16-bit LFSR word once every SAMPLE_INTERVAL
// cycles, drops warm-up and repeated samples, and buffers accepted words in a small
// first-word-fall-through FIFO drained through a valid/ready handshake.
//
// Ports:
//   CLK         system clock, rising edge
//   reset_n     synchronous active-low reset
//   lfsr_in     upstream LFSR word, bit 0 is the MSB
//   out_data    FIFO head word (0 when empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head when out_valid is high
//   level       FIFO occupancy, 0..DEPTH
//   repeat_err  one-cycle pulse after a sample equal to the previous sample
//   stuck       sticky alarm after STUCK_LIMIT consecutive repeats; reset clears it
//   drop_count  (only with RANDOM_POOL_DROP_COUNT_EN) saturating count of accepted
//               samples lost to a full FIFO or the stuck alarm
//
// Optional feature macro: RANDOM_POOL_DROP_COUNT_EN.
module random_word_pool #(
  parameter int unsigned SAMPLE_INTERVAL = 16,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned WARMUP          = 2,
  parameter int unsigned STUCK_LIMIT     = 3
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic [0:15]              lfsr_in,
  output logic [0:15]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     repeat_err,
`ifdef RANDOM_POOL_DROP_COUNT_EN
  output logic [15:0]              drop_count,
`endif
  output logic                     stuck
);

  localparam int unsigned CntW  = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned WarmW = $clog2(WARMUP + 2);
  localparam int unsigned RunW  = $clog2(STUCK_LIMIT + 2);

  logic [CntW-1:0]  cnt_q;
  logic [WarmW-1:0] warm_q;
  logic [RunW-1:0]  run_q, run_d;
  logic             have_last_q;
  logic [0:15]      last_q;
  logic             repeat_err_q;
  logic             stuck_q, stuck_d;
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic [0:15]      mem_q [DEPTH];

  logic sample, in_warmup, is_repeat, accept, full, pop, push;

  assign sample    = (cnt_q == CntW'(SAMPLE_INTERVAL - 1));
  assign in_warmup = (warm_q != '0);
  assign is_repeat = have_last_q && (lfsr_in == last_q);
  assign accept    = sample && !in_warmup && !is_repeat;
  assign full      = (level_q == LvlW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still take the new word.
  assign push      = accept && !stuck_q && (!full || pop);

  always_comb begin
    run_d = run_q;
    if (sample && !in_warmup) begin
      if (is_repeat) begin
        if (run_q != RunW'(STUCK_LIMIT)) run_d = run_q + RunW'(1);
      end else begin
        run_d = '0;
      end
    end
  end

  assign stuck_d = stuck_q || (run_d == RunW'(STUCK_LIMIT));

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      warm_q       <= WarmW'(WARMUP);
      run_q        <= '0;
      have_last_q  <= 1'b0;
      last_q       <= '0;
      repeat_err_q <= 1'b0;
      stuck_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      cnt_q        <= sample ? '0 : cnt_q + CntW'(1);
      run_q        <= run_d;
      stuck_q      <= stuck_d;
      repeat_err_q <= sample && !in_warmup && is_repeat;
      level_q      <= level_d;
      if (sample) begin
        last_q      <= lfsr_in;
        have_last_q <= 1'b1;
        if (in_warmup) warm_q <= warm_q - WarmW'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge CLK) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= lfsr_in;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign repeat_err = repeat_err_q;
  assign stuck      = stuck_q;

`ifdef RANDOM_POOL_DROP_COUNT_EN
  logic [15:0] drop_count_q;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      drop_count_q <= '0;
    end else if (accept && !push && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: doc/random_word_pool.md
Name: random_word_pool

Overview:
- Sits directly downstream of the 16-bit ring-oscillator-seeded LFSR generator and consumes its parallel output word.
- Samples the LFSR word once every SAMPLE_INTERVAL cycles, so consecutive samples are decorrelated by a full shift of fresh entropy.
- Discards warm-up and repeated words and raises a sticky stuck alarm.
- Buffers accepted words in a small FIFO that consumers drain via a valid/ready handshake.

Parameters:
- SAMPLE_INTERVAL, 16: cycles between LFSR samples; must be ≥2.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥2.
- WARMUP, 2: number of samples discarded after reset.
- STUCK_LIMIT, 3: consecutive repeated samples that set the stuck flag.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- lfsr_in  in  [0:15]  word from upstream LFSR; bit 0 is MSB, matching the LFSR output ordering.
- out_data  out  [0:15]  FIFO head word; first-word-fall-through.
- out_valid  out  1  high when FIFO is non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- repeat_err  out  1  one-cycle pulse when a sample equals the previous sample.
- stuck  out  1  sticky alarm; cleared only by reset.

Behaviour:
- Reset (reset_n low at a rising edge):
  - Interval counter = 0, warm-up counter = WARMUP, have_last = 0, repeat run = 0, FIFO flushed.
  - Outputs: out_valid = 0, level = 0, repeat_err = 0, stuck = 0. out_data = 0 when empty.
  - A reset mid-operation discards all buffered words; nothing is emitted on the cycle reset is released.
- Interval counter:
  - Counts 0..SAMPLE_INTERVAL-1 and wraps.
  - The sample event fires on the edge where the count is SAMPLE_INTERVAL-1.
  - First sample is taken on the SAMPLE_INTERVAL-th edge after reset release.
- On each sample event, in priority order:
  1. Warm-up counter > 0: discard the word and decrement the counter. last_word is still loaded and have_last is set.
  2. have_last && lfsr_in == last_word:
     - Discard the word and pulse repeat_err for the following cycle.
     - Increment the repeat run. When it reaches STUCK_LIMIT, set stuck.
  3. Otherwise: clear the repeat run; push the word unless stuck or the FIFO is full. A word arriving while full is silently dropped.
  - last_word <= lfsr_in on every sample event.
- While stuck = 1: no pushes; sampling and repeat detection continue. Buffered words remain drainable.
- FIFO:
  - Pop occurs on out_valid && out_ready.
  - Push-to-out_valid latency is 1 cycle: the word is visible the cycle after the sample edge.
  - Push and pop on the same edge when full: both happen, level is unchanged.
  - Push and pop on the same edge when empty: impossible, because out_valid = 0.
  - Read and write pointers wrap modulo DEPTH. level is exact from 0 to DEPTH.
- out_ready while out_valid = 0 has no effect.

Optional Feature:
- Macro: RANDOM_POOL_DROP_COUNT_EN.
- When defined: adds output drop_count [15:0].
  - Increments by 1 on each sample that passed warm-up and repeat checks but was dropped because the FIFO was full or stuck was set.
  - Saturates at 16'hFFFF. Reset value 0.
- When undefined: the port and counter are absent; drop behaviour is otherwise identical.

Test Plan:
All scenarios use default parameters. "Cycle N" means the Nth rising edge after reset_n rises.
1. Warm-up and first output: lfsr_in changes every cycle, out_ready = 0.
   - Samples at cycles 16 and 32 are discarded; the sample at 48 is pushed.
   - out_valid = 1 and level = 1 at cycle 49.
   - level = 4 after cycle 96; the sample at cycle 112 is dropped and level stays 4.
2. Ordering: after warm-up, drive 16'h1111, 16'h2222, 16'h3333 at consecutive sample events with out_ready = 1.
   - out_data shows 1111, 2222, 3333 in that order, each for exactly one cycle.
   - level returns to 0.
3. Repeat and stuck: after warm-up, hold lfsr_in = 16'hA5A5.
   - First sample is pushed.
   - The next three samples each pulse repeat_err. stuck = 1 after the third repeat and stays 1.
   - Changing lfsr_in afterwards does not clear stuck and produces no push.
4. Full with simultaneous pop/push: fill to level = 4, then assert out_ready exactly on a sample edge with a new word.
   - Head is popped, new word enqueued, level stays 4.
   - The drained sequence ends with the new word.
5. Reset mid-operation: with level = 3, pull reset_n low for one edge.
   - level = 0, out_valid = 0, stuck = 0.
   - The next push occurs only after 2 fresh warm-up samples, at cycle 48 after release.
